vga_hv_counter: RTL and testbench

//  - Raster timing generator for a VGA display: horizontal pixel counter and vertical line counter, with HSYNC/VSYNC.
//  - Defaults give 640x480@60 timing: 800x525 total, 25 MHz pixel rate.
//  - Sits between the clock/enable generator and the pixel/colour logic.
//  - Downstream logic uses hori_cnt/vert_cnt as the current pixel coordinate.

---
 rtl/vga_timing_pkg.sv | 20 ++
 rtl/vga_axis_counter.sv | 50 +++++
 rtl/vga_hv_counter.sv | 111 +++++++++++
 tb/tb_vga_hv_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants and the counter type.
// Defaults describe 640x480@60: 800 pixels x 525 lines at a 25 MHz pixel rate.
package vga_timing_pkg;

    localparam int CNT_W         = 10;
    localparam int CNT_MAX_TOTAL = 1 << CNT_W;

    localparam int H_ACTIVE_DEF  = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;

    localparam int V_ACTIVE_DEF  = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    typedef logic [CNT_W-1:0] vga_cnt_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus a registered sync flag.
// The sync flop is loaded from the next count value, so sync always matches
// the count that is visible in the same cycle.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   TOTAL      = 800,
    parameter int   SYNC_START = 656,
    parameter int   SYNC_LEN   = 96,
    parameter logic SYNC_POL   = 1'b0
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     step,
    output vga_cnt_t cnt,
    output logic     wrap,
    output logic     sync
);

    localparam vga_cnt_t LAST       = vga_cnt_t'(TOTAL - 1);
    localparam vga_cnt_t SYNC_FIRST = vga_cnt_t'(SYNC_START);
    localparam vga_cnt_t SYNC_LAST  = vga_cnt_t'(SYNC_START + SYNC_LEN - 1);

    vga_cnt_t cnt_q, cnt_d;
    logic     sync_q, sync_d;

    // Terminal count: the next step returns the axis to zero.
    assign wrap = (cnt_q == LAST);

    // Next count and the sync level that belongs to it.
    always_comb begin
        cnt_d  = wrap ? '0 : cnt_q + vga_cnt_t'(1);
        sync_d = ((cnt_d >= SYNC_FIRST) && (cnt_d <= SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
    end

    // Count and sync only move on a step; otherwise everything holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            sync_q <= ~SYNC_POL;
        end else if (step) begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
        end
    end

    assign cnt  = cnt_q;
    assign sync = sync_q;

endmodule

// File: rtl/vga_hv_counter.sv
// VGA raster timing generator: horizontal pixel and vertical line counters
// with HSYNC/VSYNC, advancing once per enable strobe.
// Optional macro VGA_HV_ACTIVE_OUT_EN adds video_active and frame_start.
module vga_hv_counter
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic [9:0] hori_cnt,
    output logic [9:0] vert_cnt
`ifdef VGA_HV_ACTIVE_OUT_EN
    ,
    output logic       video_active,
    output logic       frame_start
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Totals must fit the 10-bit counters.
    if (H_TOTAL > CNT_MAX_TOTAL) begin : g_bad_h_total
        $error("vga_hv_counter: H_TOTAL %0d exceeds %0d", H_TOTAL, CNT_MAX_TOTAL);
    end
    if (V_TOTAL > CNT_MAX_TOTAL) begin : g_bad_v_total
        $error("vga_hv_counter: V_TOTAL %0d exceeds %0d", V_TOTAL, CNT_MAX_TOTAL);
    end

    vga_cnt_t h_cnt, v_cnt;
    logic     h_wrap, v_wrap;
    logic     v_step;

    // Lines advance only on the pixel strobe that ends a line.
    assign v_step = enable & h_wrap;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_LEN   (H_SYNC),
        .SYNC_POL   (SYNC_POL)
    ) u_hori (
        .clk   (clk),
        .reset (reset),
        .step  (enable),
        .cnt   (h_cnt),
        .wrap  (h_wrap),
        .sync  (HSYNC)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_LEN   (V_SYNC),
        .SYNC_POL   (SYNC_POL)
    ) u_vert (
        .clk   (clk),
        .reset (reset),
        .step  (v_step),
        .cnt   (v_cnt),
        .wrap  (v_wrap),
        .sync  (VSYNC)
    );

    assign hori_cnt = h_cnt;
    assign vert_cnt = v_cnt;

`ifdef VGA_HV_ACTIVE_OUT_EN
    vga_cnt_t h_next, v_next;
    logic     active_q, active_d;
    logic     frame_q, frame_d;

    // Next coordinates, so the flags line up with the counts they describe.
    always_comb begin
        h_next   = h_wrap ? '0 : h_cnt + vga_cnt_t'(1);
        v_next   = v_step ? (v_wrap ? '0 : v_cnt + vga_cnt_t'(1)) : v_cnt;
        active_d = (h_next < vga_cnt_t'(H_ACTIVE)) && (v_next < vga_cnt_t'(V_ACTIVE));
        frame_d  = h_wrap & v_wrap;
    end

    // Flags update with the counters and hold while enable is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            frame_q  <= 1'b0;
        end else if (enable) begin
            active_q <= active_d;
            frame_q  <= frame_d;
        end
    end

    assign video_active = active_q;
    assign frame_start  = frame_q;
`else
    logic v_wrap_unused;
    assign v_wrap_unused = v_wrap;
`endif

endmodule

// File: tb/tb_vga_hv_counter.sv
// Bench for vga_hv_counter: a default 640x480 instance and a tiny-timing
// instance with active-high sync so whole frames fit in a short run.
// Both are compared every cycle against a model that derives the raster
// position from the number of enabled strobes since reset.
module tb_vga_hv_counter;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit pol;
    } cfg_t;

    typedef struct {
        int h, v;
        bit hs, vs, act, fs;
    } exp_t;

    localparam cfg_t CFG_STD   = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    localparam cfg_t CFG_SMALL = '{8, 2, 3, 3, 6, 2, 2, 3, 1'b1};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;

    logic       hs_std, vs_std, hs_sm, vs_sm;
    logic [9:0] h_std, v_std, h_sm, v_sm;
`ifdef VGA_HV_ACTIVE_OUT_EN
    logic       act_std, fs_std, act_sm, fs_sm;
`endif

    int     tests_run    = 0;
    int     tests_failed = 0;
    longint n_steps      = 0;

    always #5 clk = ~clk;

    vga_hv_counter u_dut_std (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .HSYNC    (hs_std),
        .VSYNC    (vs_std),
        .hori_cnt (h_std),
        .vert_cnt (v_std)
`ifdef VGA_HV_ACTIVE_OUT_EN
        ,
        .video_active (act_std),
        .frame_start  (fs_std)
`endif
    );

    vga_hv_counter #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .SYNC_POL (1'b1)
    ) u_dut_small (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .HSYNC    (hs_sm),
        .VSYNC    (vs_sm),
        .hori_cnt (h_sm),
        .vert_cnt (v_sm)
`ifdef VGA_HV_ACTIVE_OUT_EN
        ,
        .video_active (act_sm),
        .frame_start  (fs_sm)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t, steps=%0d)", tag, obs, exp, $time, n_steps);
        end
    endtask

    // Raster position follows directly from how many strobes have elapsed.
    function automatic exp_t model(input cfg_t c, input longint n);
        exp_t   e;
        longint ht, vt;
        ht    = c.ha + c.hf + c.hs + c.hb;
        vt    = c.va + c.vf + c.vs + c.vb;
        e.h   = int'(n % ht);
        e.v   = int'((n / ht) % vt);
        e.hs  = (e.h >= c.ha + c.hf && e.h < c.ha + c.hf + c.hs) ? c.pol : !c.pol;
        e.vs  = (e.v >= c.va + c.vf && e.v < c.va + c.vf + c.vs) ? c.pol : !c.pol;
        e.act = (n > 0) && (e.h < c.ha) && (e.v < c.va);
        e.fs  = (n > 0) && (n % (ht * vt) == 0);
        return e;
    endfunction

    task automatic check_all(input string tag);
        exp_t es, em;
        es = model(CFG_STD, n_steps);
        em = model(CFG_SMALL, n_steps);
        check_val({tag, ".std.hori"},  32'(h_std),  32'(es.h));
        check_val({tag, ".std.vert"},  32'(v_std),  32'(es.v));
        check_val({tag, ".std.hsync"}, 32'(hs_std), 32'(es.hs));
        check_val({tag, ".std.vsync"}, 32'(vs_std), 32'(es.vs));
        check_val({tag, ".sm.hori"},   32'(h_sm),   32'(em.h));
        check_val({tag, ".sm.vert"},   32'(v_sm),   32'(em.v));
        check_val({tag, ".sm.hsync"},  32'(hs_sm),  32'(em.hs));
        check_val({tag, ".sm.vsync"},  32'(vs_sm),  32'(em.vs));
`ifdef VGA_HV_ACTIVE_OUT_EN
        check_val({tag, ".std.active"}, 32'(act_std), 32'(es.act));
        check_val({tag, ".std.fstart"}, 32'(fs_std),  32'(es.fs));
        check_val({tag, ".sm.active"},  32'(act_sm),  32'(em.act));
        check_val({tag, ".sm.fstart"},  32'(fs_sm),   32'(em.fs));
`endif
    endtask

    // Drive enable for one clock, advance the model on an enabled edge,
    // then compare on the falling edge.
    task automatic step_cycle(input logic en, input string tag);
        enable = en;
        @(posedge clk);
        if (en) n_steps++;
        @(negedge clk);
        check_all(tag);
    endtask

    // Called on a falling edge; outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        n_steps = 0;
        check_all({tag, ".async"});
        @(posedge clk);
        @(negedge clk);
        check_all({tag, ".held"});
        reset = 1'b1;
    endtask

    initial begin
        @(negedge clk);

        // Reset and idle with enable low.
        do_reset("rst0");
        check_val("rst.std.hsync_high", 32'(hs_std), 32'd1);
        check_val("rst.std.vsync_high", 32'(vs_std), 32'd1);
        check_val("rst.sm.hsync_low",   32'(hs_sm),  32'd0);
        for (int i = 0; i < 10; i++) step_cycle(1'b0, "idle");
        check_val("idle.std.hori", 32'(h_std), 32'd0);
        check_val("idle.std.vert", 32'(v_std), 32'd0);

        // Continuous enable for 1000 cycles with the line-timing landmarks.
        for (int i = 1; i <= 1000; i++) begin
            step_cycle(1'b1, "cont");
            if (i == 655) check_val("cont.hsync_before_656", 32'(hs_std), 32'd1);
            if (i == 656) check_val("cont.hsync_at_656",     32'(hs_std), 32'd0);
            if (i == 751) check_val("cont.hsync_at_751",     32'(hs_std), 32'd0);
            if (i == 752) check_val("cont.hsync_at_752",     32'(hs_std), 32'd1);
            if (i == 799) check_val("cont.hori_799",         32'(h_std),  32'd799);
            if (i == 800) begin
                check_val("cont.hori_wrap", 32'(h_std), 32'd0);
                check_val("cont.vert_inc",  32'(v_std), 32'd1);
            end
        end
        check_val("cont.hori_1000", 32'(h_std), 32'd200);
        check_val("cont.vert_1000", 32'(v_std), 32'd1);

        // Small instance: one full frame from reset lands back on (0,0).
        @(negedge clk);
        do_reset("rst1");
        for (int i = 0; i < 208; i++) begin
            step_cycle(1'b1, "frame");
`ifdef VGA_HV_ACTIVE_OUT_EN
            if (i + 1 == 87) check_val("frame.sm.active_last_px", 32'(act_sm), 32'd1);
            if (i + 1 == 88) check_val("frame.sm.active_after",   32'(act_sm), 32'd0);
`endif
        end
        check_val("frame.sm.hori_wrap", 32'(h_sm), 32'd0);
        check_val("frame.sm.vert_wrap", 32'(v_sm), 32'd0);
`ifdef VGA_HV_ACTIVE_OUT_EN
        check_val("frame.sm.fstart_pulse", 32'(fs_sm), 32'd1);
        step_cycle(1'b1, "frame_post");
        check_val("frame.sm.fstart_drop", 32'(fs_sm), 32'd0);
`endif

        // Gapped enable: one strobe in four.
        for (int i = 0; i < 1600; i++) step_cycle((i % 4) == 3, "gap");

        // Random enable density.
        for (int i = 0; i < 3000; i++) step_cycle($urandom_range(0, 3) != 0, "rand");

        // Walk to (300,7) on the default instance, then reset mid-line.
        @(negedge clk);
        do_reset("rst2");
        for (int i = 0; i < 7 * 800 + 300; i++) step_cycle(1'b1, "walk");
        check_val("walk.std.hori_300", 32'(h_std), 32'd300);
        check_val("walk.std.vert_7",   32'(v_std), 32'd7);
        do_reset("midline");
        check_val("midline.std.hori_0",  32'(h_std),  32'd0);
        check_val("midline.std.hsync_1", 32'(hs_std), 32'd1);

        // Short random run after the mid-line reset.
        for (int i = 0; i < 500; i++) step_cycle($urandom_range(0, 1) == 1, "post");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
